// File: rtl/hdb_n_plug_vb_pkg.sv
// ---------------------------------------------------------------------------
// hdb_pkg -- shared definitions for the HDBn zero-substitution marker and the
// downstream polarity/AMI stage.
//   sym_t           : 2-bit line symbol code
//   SYM_ZERO/ONE/V/B: symbol encodings (00 zero, 01 one, 11 violation, 10 B)
//   ZERO_RUN_MIN/MAX: legal range of the zero-run length parameter
// ---------------------------------------------------------------------------
package hdb_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_ZERO = 2'b00;
  localparam sym_t SYM_ONE  = 2'b01;
  localparam sym_t SYM_V    = 2'b11;
  localparam sym_t SYM_B    = 2'b10;

  localparam int ZERO_RUN_MIN = 2;
  localparam int ZERO_RUN_MAX = 8;

endpackage

// File: rtl/hdb_n_plug_vb_if.sv
// ---------------------------------------------------------------------------
// hdb_n_plug_vb_if -- stream interface of the HDBn marker.
//   en        : stream enable (low = synchronous clear)
//   data_in   : NRZ data bit
//   data_out  : 2-bit symbol code
//   valid_out : data_out carries a symbol from en-qualified input
//   v_pulse   : one-cycle flag, a V has just entered the buffer
// master = NRZ source side, slave = marker.
// ---------------------------------------------------------------------------
interface hdb_n_plug_vb_if;
  import hdb_pkg::*;

  logic en;
  logic data_in;
  sym_t data_out;
  logic valid_out;
  logic v_pulse;

  modport master (
    output en, data_in,
    input  data_out, valid_out, v_pulse
  );

  modport slave (
    input  en, data_in,
    output data_out, valid_out, v_pulse
  );

endinterface

// File: rtl/hdb_n_plug_vb_sym_delay.sv
// ---------------------------------------------------------------------------
// hdb_sym_delay -- DEPTH-deep shift buffer of 2-bit symbols with a tail
// overwrite port, plus a matching valid pipe.
//   clk, rst_n : clock, async active-low reset
//   en         : shift enable; low clears buffer and valid pipe synchronously
//   sym_in     : symbol entering stage 0
//   tail_load  : replace the symbol shifting into the last stage
//   tail_sym   : symbol used for that replacement
//   sym_out    : last stage (registered)
//   valid_out  : last stage of the valid pipe
// ---------------------------------------------------------------------------
module hdb_sym_delay
  import hdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  sym_t sym_in,
  input  logic tail_load,
  input  sym_t tail_sym,
  output sym_t sym_out,
  output logic valid_out
);

  sym_t             sr [DEPTH];
  logic [DEPTH-1:0] vpipe;

  // NOTE: the buffer is a handful of flops, not a RAM, so every stage is
  // reset; a stale symbol here would otherwise leak onto the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) sr[j] <= SYM_ZERO;
      vpipe <= '0;
    end else if (!en) begin
      for (int j = 0; j < DEPTH; j++) sr[j] <= SYM_ZERO;
      vpipe <= '0;
    end else begin
      sr[0] <= sym_in;
      for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
      // Later assignment wins: the tail slot takes the B instead of the
      // symbol shifting in from the previous stage.
      if (tail_load) sr[DEPTH-1] <= tail_sym;
      vpipe <= {vpipe[DEPTH-2:0], 1'b1};
    end
  end

  assign sym_out   = sr[DEPTH-1];
  assign valid_out = vpipe[DEPTH-1];

endmodule

// File: rtl/hdb_n_plug_vb.sv
// ---------------------------------------------------------------------------
// hdb_n_plug_vb -- HDBn zero-substitution marker (HDB3 by default).
// Classifies each NRZ bit as one / zero / V, tracks pulse parity since the
// last V and, when parity is even, retroactively marks the first zero of the
// run as B. Output is symbol codes only; polarity is applied downstream.
//   clk, rst_n : clock, async active-low reset
//   bus        : hdb_n_plug_vb_if slave (en, data_in, data_out, valid_out,
//                v_pulse)
// Parameters:
//   ZERO_RUN   : zero-run length triggering substitution (2..8)
//   B_ENABLE   : 1 = insert B on even parity, 0 = V marking only
// ---------------------------------------------------------------------------
module hdb_n_plug_vb
  import hdb_pkg::*;
#(
  parameter int ZERO_RUN = 4,
  parameter int B_ENABLE = 1
) (
  input logic           clk,
  input logic           rst_n,
  hdb_n_plug_vb_if.slave bus
);

  // Out-of-range values are clamped to the nearest legal run length.
  localparam int ZR = (ZERO_RUN < ZERO_RUN_MIN) ? ZERO_RUN_MIN :
                      (ZERO_RUN > ZERO_RUN_MAX) ? ZERO_RUN_MAX : ZERO_RUN;
  localparam int CW   = $clog2(ZR);
  localparam bit B_ON = (B_ENABLE != 0);

  logic [CW-1:0] zero_cnt;
  logic          parity_odd;
  logic          v_pulse_q;
  sym_t          code;
  logic          is_v;
  logic          tail_load;

  // Classifier.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and a latch is never inferred.
  always_comb begin
    code = SYM_ZERO;
    is_v = 1'b0;
    if (bus.data_in) begin
      code = SYM_ONE;
    end else if (zero_cnt == CW'(ZR - 1)) begin
      code = SYM_V;
      is_v = 1'b1;
    end
  end

  // Parity is the pre-edge value: B goes in when an even number of ones were
  // written since the last V (or since clear).
  assign tail_load = bus.en && is_v && B_ON && !parity_odd;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt   <= '0;
      parity_odd <= 1'b0;
      v_pulse_q  <= 1'b0;
    end else if (!bus.en) begin
      zero_cnt   <= '0;
      parity_odd <= 1'b0;
      v_pulse_q  <= 1'b0;
    end else begin
      v_pulse_q <= is_v;
      if (bus.data_in || is_v) zero_cnt <= '0;
      else                     zero_cnt <= zero_cnt + CW'(1);
      if (is_v)                parity_odd <= 1'b0;
      else if (code == SYM_ONE) parity_odd <= ~parity_odd;
    end
  end

  hdb_sym_delay #(
    .DEPTH (ZR)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .sym_in    (code),
    .tail_load (tail_load),
    .tail_sym  (SYM_B),
    .sym_out   (bus.data_out),
    .valid_out (bus.valid_out)
  );

  assign bus.v_pulse = v_pulse_q;

endmodule

// File: doc/hdb_n_plug_vb.md
Name: hdb_n_plug_vb

Overview:
- Parametrised zero-substitution marker for HDBn line coding (HDB3 by default).
- Classifies each input bit as one, zero, violation (V) or balancing pulse (B).
- Buffers ZERO_RUN-1 symbols so a B can be placed retroactively at the start of a zero run.
- Sits between the serial NRZ source and the polarity/AMI stage; outputs 2-bit symbol codes only, no polarity.

Parameters:
- ZERO_RUN, 4, zero-run length triggering substitution; legal 2..8 (4 = HDB3, 3 = HDB2).
- B_ENABLE, 1, 1 = insert B per HDB parity rule; 0 = V marking only, B never emitted.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  stream enable; low = synchronous clear of all state.
- data_in  input  1  NRZ data bit, sampled every clk edge while en=1.
- data_out  output  2  symbol code: 00 zero, 01 one, 11 V, 10 B.
- valid_out  output  1  high when data_out carries a symbol derived from en-qualified input.
- v_pulse  output  1  one-cycle high on the edge a V symbol enters the buffer.

Behaviour:
- Reset (rst_n low, async): zero counter, parity, symbol buffer, valid pipe all cleared; data_out=00, valid_out=0, v_pulse=0.
- en low at an edge: same clearing as reset, synchronously. An in-progress run is discarded; no V or B is produced for it.
- Classification (combinational on data_in, en=1):
  - data_in=1 -> code 01; zero counter cleared.
  - data_in=0 with counter < ZERO_RUN-1 -> code 00; counter increments.
  - data_in=0 with counter == ZERO_RUN-1 -> code 11 (V); counter cleared.
- Counter width: clog2(ZERO_RUN); no wrap beyond ZERO_RUN-1.
- Parity flag: toggles on each code 01 written. Cleared when V is written. Cleared (even) at reset/en low.
- Symbol buffer: sr[0..ZERO_RUN-1], 2 bits each. Each enabled edge: sr[0] <= code, sr[j] <= sr[j-1].
- After edge k, sr[j] holds the symbol sampled at edge k-j.
- data_out = sr[ZERO_RUN-1] (registered). Latency: input sampled at edge k appears after edge k+ZERO_RUN-1 (3 cycles for HDB3).
- B insertion: on the edge V is written to sr[0], if B_ENABLE=1 and parity is even, sr[ZERO_RUN-1] is loaded with 10 instead of the shifted 00. That slot holds the first zero of the same run.
- Parity is evaluated before that edge's update.
- Back-to-back runs (2*ZERO_RUN zeros): the second run starts with parity even, so both runs get B (B00V B00V).
- V and 01 are mutually exclusive per cycle. The B slot is always a 00 at that edge by construction; the design must not depend on this.
- valid_out: ZERO_RUN-stage shift of en. Goes high ZERO_RUN-1 edges after en rises; drops at the first edge with en low.
- v_pulse: registered, high for exactly the cycle after the V-writing edge.

Decomposition:
- Shared package hdb_pkg:
  - symbol code constants SYM_ZERO, SYM_ONE, SYM_V, SYM_B.
  - 2-bit symbol typedef.
  - ZERO_RUN legal range constants. The downstream polarity stage imports the same codes.
- One natural sub-module: hdb_sym_delay, the parametrised ZERO_RUN-deep 2-bit shift buffer with tail-overwrite port and valid pipe.
- Classifier, counter and parity stay in the top module.

Test Plan:
All sequences with en=1 after reset; output lists are the first symbols after valid_out rises.
1. Reset mid-stream (rst_n pulsed low between edges during a zero run) -> data_out=00, valid_out=0 immediately; the next run is counted from zero.
2. ZERO_RUN=4, data_in 1,0,0,0,0 -> data_out 01,00,00,00,11 (parity odd, no B); v_pulse once.
3. ZERO_RUN=4, eight zeros -> data_out 10,00,00,11,10,00,00,11; v_pulse twice, 4 cycles apart.
4. ZERO_RUN=4, data_in 1,1,0,0,0,0 -> 01,01,10,00,00,11 (two ones = even, B inserted).
5. ZERO_RUN=4, data_in 1,0,0, en low one cycle, then 0,0 -> no 11 or 10 emitted; valid_out low during refill; outputs 00.
6. ZERO_RUN=3, B_ENABLE=0, six zeros -> 00,00,11,00,00,11; never 10.
